// File: rtl/serial_adder_sub_pkg.sv
// rtl/serial_adder_sub_pkg.sv - shared FSM state encodings and ALU op codes for the serial adder/subtractor
package serial_adder_sub_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ALU op codes as seen on the sub input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder used as the serial bit cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of one bit position
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder_sub.sv
// rtl/serial_adder_sub.sv - bit-serial add/subtract, LSB first, one full adder reused over WIDTH cycles
module serial_adder_sub
  import serial_adder_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             cout_bit;
  logic [WIDTH-1:0] s_shift;

  // The one shared bit cell: current LSBs plus the running carry
  full_adder u_bit_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (sum_bit),
    .cout (cout_bit)
  );

  // Result register after this bit lands at the MSB end
  assign s_shift = {sum_bit, s[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control; DONE accepts a new start like IDLE
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Operand shifters, carry, counter, result and flags; subtraction is a + ~b + 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      s        <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      a_sh     <= a;
      b_sh     <= (sub == OP_SUB) ? ~b : b;
      carry    <= sub;
      cnt      <= '0;
      s        <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= cout_bit;
      cnt   <= cnt + 1'b1;
      s     <= s_shift;
      if (cnt == LAST) begin
        cout     <= cout_bit;
        overflow <= carry ^ cout_bit;
        zero     <= (s_shift == '0);
      end
    end
  end

endmodule
